i2c_avalon_bridge_mc: RTL and testbench

- Multi-channel I2C master bridge with an Avalon-MM slave register interface.
- Generalises the single-bus bridge to NUM_CH buses served by one shared byte engine; CH_SEL chooses the bus for each transaction.
- Carries parametrised GPIO/LED outputs and adds read bursts with repeated START.
- Sits in the FPGA fabric behind the HPS lightweight bridge.

---
 rtl/i2c_avalon_bridge_mc.sv | 271 +++++++++++++++++++++++++++
 tb/tb_i2c_avalon_bridge_mc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_avalon_bridge_mc.sv
// Multi-channel I2C master behind an Avalon-MM slave: one byte engine shared by NUM_CH open-drain buses.
// Optional clock stretching is enabled by defining I2C_CLOCK_STRETCH_EN.
module i2c_avalon_bridge_mc #(
  parameter int NUM_CH  = 2,
  parameter int CLK_DIV = 31,
  parameter int GPIO_W  = 3,
  parameter int LED_W   = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        address,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic              read,
  output logic [31:0]       readdata,
  inout  wire  [NUM_CH-1:0] scl,
  inout  wire  [NUM_CH-1:0] sda,
  output logic [GPIO_W-1:0] gpio,
  output logic [LED_W-1:0]  led
);

  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);
  localparam logic [3:0] NUM_CH4 = 4'(NUM_CH);

  localparam logic [3:0] IDLE   = 4'd0,  START  = 4'd1,  ADDR_W = 4'd2,  ACK_AW = 4'd3,
                         REG    = 4'd4,  ACK_R  = 4'd5,  WDATA  = 4'd6,  ACK_WD = 4'd7,
                         RSTART = 4'd8,  ADDR_R = 4'd9,  ACK_AR = 4'd10, RDATA  = 4'd11,
                         MACK   = 4'd12, STOP   = 4'd13;

  localparam logic [3:0] A_CTRL = 4'd0, A_DEV = 4'd1, A_REG = 4'd2, A_TX = 4'd3, A_NUM = 4'd4,
                         A_CH   = 4'd5, A_STAT = 4'd6, A_RX = 4'd7, A_GPIO = 4'd8;

  // Software-visible configuration and the copy used by the running transaction.
  logic        rnw;
  logic [6:0]  dev;
  logic [7:0]  reg_a;
  logic [31:0] tx;
  logic [1:0]  num;
  logic [2:0]  ch_sel;
  logic        s_rnw;
  logic [6:0]  s_dev;
  logic [7:0]  s_reg;
  logic [31:0] s_tx;
  logic [1:0]  s_num;
  logic [2:0]  ch_sh;

  logic [3:0]    state;
  logic [1:0]    qtr;
  logic [QW-1:0] qcnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [7:0]    shift;
  logic [7:0]    rx_sh;
  logic [31:0]   rx_data;
  logic          sda_r;
  logic          ack_bit;
  logic          nack, done, ch_err;

  logic busy, go, qtick, txn_done, scl_rel, sda_in;
  logic stretch_wait, stretch_to;
  logic [1:0] nb;

  assign busy     = (state != IDLE);
  assign go       = write && (address == A_CTRL) && writedata[0];
  assign qtick    = (qcnt == Q_LAST);
  assign txn_done = (state == STOP) && (qtr == 2'd3) && qtick;
  assign nb       = byte_cnt + 2'd1;

  // SCL is held low for the first two quarters of every bit; START inverts this so the bus idles high.
  assign scl_rel = (state == IDLE) ? 1'b1 : (state == START) ? ~qtr[1] : qtr[1];

  // NOTE: combinational blocks assign a default first so no path leaves the output unassigned (no latch).
  always_comb begin
    sda_in = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_sh == 3'(i)) sda_in = sda[i];
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_bus
    assign scl[i] = (busy && ch_sh == 3'(i) && !scl_rel) ? 1'b0 : 1'bz;
    assign sda[i] = (busy && ch_sh == 3'(i) && !sda_r)   ? 1'b0 : 1'bz;
  end

`ifdef I2C_CLOCK_STRETCH_EN
  logic        scl_in;
  logic [15:0] stretch_cnt;

  always_comb begin
    scl_in = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_sh == 3'(i)) scl_in = scl[i];
  end

  assign stretch_wait = busy && scl_rel && (qcnt == '0) && !scl_in;
  assign stretch_to   = stretch_wait && (stretch_cnt == 16'hFFFF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          stretch_cnt <= '0;
    else if (stretch_wait) stretch_cnt <= stretch_cnt + 16'd1;
    else                   stretch_cnt <= '0;
  end
`else
  assign stretch_wait = 1'b0;
  assign stretch_to   = 1'b0;
`endif

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rnw <= 1'b0;  dev <= '0;  reg_a <= '0;  tx <= '0;  num <= '0;  ch_sel <= '0;
      s_rnw <= 1'b0; s_dev <= '0; s_reg <= '0; s_tx <= '0; s_num <= '0; ch_sh <= '0;
      gpio <= '0;
      state <= IDLE; qtr <= '0; qcnt <= '0; bit_cnt <= '0; byte_cnt <= '0;
      shift <= '0; rx_sh <= '0; rx_data <= '0; sda_r <= 1'b1; ack_bit <= 1'b1;
      nack <= 1'b0; done <= 1'b0; ch_err <= 1'b0;
    end else begin
      if (write) begin
        case (address)
          A_CTRL: rnw    <= writedata[1];
          A_DEV:  dev    <= writedata[6:0];
          A_REG:  reg_a  <= writedata[7:0];
          A_TX:   tx     <= writedata;
          A_NUM:  num    <= writedata[1:0];
          A_CH:   ch_sel <= writedata[2:0];
          A_GPIO: gpio   <= writedata[GPIO_W-1:0];
          default: ;
        endcase
      end

      if (state == IDLE) begin
        qtr   <= '0;
        qcnt  <= '0;
        sda_r <= 1'b1;
        if (go) begin
          if ({1'b0, ch_sel} >= NUM_CH4) begin
            ch_err <= 1'b1;
            done   <= 1'b0;
            nack   <= 1'b0;
          end else begin
            s_rnw <= writedata[1]; s_dev <= dev; s_reg <= reg_a;
            s_tx  <= tx;           s_num <= num; ch_sh <= ch_sel;
            nack  <= 1'b0; done <= 1'b0; ch_err <= 1'b0; rx_data <= '0;
            state <= START;
          end
        end
      end else if (stretch_to) begin
        nack  <= 1'b1;
        state <= STOP;
        qtr   <= '0;
        qcnt  <= '0;
      end else if (!stretch_wait) begin
        qcnt <= qtick ? '0 : qcnt + 1'b1;
        if (qtick) begin
          qtr <= qtr + 2'd1;
          case (qtr)
            // Middle of SCL low: the only point where SDA moves for data bits.
            2'd0: begin
              case (state)
                START, STOP:                   sda_r <= 1'b0;
                ADDR_W, REG, WDATA, ADDR_R:    sda_r <= shift[7];
                MACK:                          sda_r <= (byte_cnt == s_num);
                default:                       sda_r <= 1'b1;
              endcase
            end
            2'd2: begin
              ack_bit <= sda_in;
              if (state == RDATA)  rx_sh <= {rx_sh[6:0], sda_in};
              if (state == RSTART) sda_r <= 1'b0;
              if (state == STOP)   sda_r <= 1'b1;
            end
            2'd3: begin
              case (state)
                START: begin
                  state <= ADDR_W; shift <= {s_dev, 1'b0}; bit_cnt <= 3'd7;
                end
                ADDR_W, REG, WDATA, ADDR_R: begin
                  if (bit_cnt == 3'd0) begin
                    case (state)
                      ADDR_W:  state <= ACK_AW;
                      REG:     state <= ACK_R;
                      WDATA:   state <= ACK_WD;
                      default: state <= ACK_AR;
                    endcase
                  end else begin
                    bit_cnt <= bit_cnt - 3'd1;
                    shift   <= {shift[6:0], 1'b0};
                  end
                end
                ACK_AW: begin
                  if (ack_bit) begin nack <= 1'b1; state <= STOP; end
                  else begin state <= REG; shift <= s_reg; bit_cnt <= 3'd7; end
                end
                ACK_R: begin
                  if (ack_bit)    begin nack <= 1'b1; state <= STOP; end
                  else if (s_rnw) state <= RSTART;
                  else begin
                    state <= WDATA; shift <= s_tx[7:0]; bit_cnt <= 3'd7; byte_cnt <= '0;
                  end
                end
                ACK_WD: begin
                  if (ack_bit)                    begin nack <= 1'b1; state <= STOP; end
                  else if (byte_cnt == s_num)     state <= STOP;
                  else begin
                    byte_cnt <= nb; state <= WDATA; bit_cnt <= 3'd7;
                    shift    <= s_tx[{nb, 3'b000} +: 8];
                  end
                end
                RSTART: begin
                  state <= ADDR_R; shift <= {s_dev, 1'b1}; bit_cnt <= 3'd7;
                end
                ACK_AR: begin
                  if (ack_bit) begin nack <= 1'b1; state <= STOP; end
                  else begin state <= RDATA; bit_cnt <= 3'd7; byte_cnt <= '0; end
                end
                RDATA: begin
                  if (bit_cnt == 3'd0) begin
                    rx_data[{byte_cnt, 3'b000} +: 8] <= rx_sh;
                    state <= MACK;
                  end else begin
                    bit_cnt <= bit_cnt - 3'd1;
                  end
                end
                MACK: begin
                  if (byte_cnt == s_num) state <= STOP;
                  else begin byte_cnt <= nb; state <= RDATA; bit_cnt <= 3'd7; end
                end
                STOP: begin
                  state <= IDLE;
                  done  <= 1'b1;
                end
                default: state <= IDLE;
              endcase
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else if (read) begin
      case (address)
        A_CTRL:  readdata <= {30'd0, rnw, 1'b0};
        A_DEV:   readdata <= {25'd0, dev};
        A_REG:   readdata <= {24'd0, reg_a};
        A_TX:    readdata <= tx;
        A_NUM:   readdata <= {30'd0, num};
        A_CH:    readdata <= {29'd0, ch_sel};
        A_STAT:  readdata <= {28'd0, ch_err, done, nack, busy};
        A_RX:    readdata <= rx_data;
        A_GPIO:  readdata <= 32'(gpio);
        default: readdata <= '0;
      endcase
    end
  end

  if (LED_W > 3) begin : g_txn
    logic [LED_W-4:0] txn_cnt;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      txn_cnt <= '0;
      else if (txn_done) txn_cnt <= txn_cnt + 1'b1;
    end
    assign led = {txn_cnt, done, nack, busy};
  end else begin : g_no_txn
    assign led = {done, nack, busy};
  end

endmodule

// File: tb/tb_i2c_avalon_bridge_mc.sv
// Bench for i2c_avalon_bridge_mc: an I2C slave model on bus 1 feeds observed bus events to a scoreboard
// of expected events; register results are checked directly.
module tb_i2c_avalon_bridge_mc;

  localparam int NCH  = 2;
  localparam int CDIV = 4;
  localparam int GW   = 3;
  localparam int LW   = 7;
  localparam logic [6:0] SLV = 7'h68;
  localparam int EV_S  = 32'h1000;
  localparam int EV_SR = 32'h1001;
  localparam int EV_P  = 32'h1002;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    address = '0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic          read = 1'b0;
  logic [31:0]   readdata;
  wire [NCH-1:0] scl;
  wire [NCH-1:0] sda;
  logic [GW-1:0] gpio;
  logic [LW-1:0] led;

  logic slv_drv = 1'b0;
  assign sda[1] = slv_drv ? 1'b0 : 1'bz;

  for (genvar i = 0; i < NCH; i++) begin : g_pu
    pullup (scl[i]);
    pullup (sda[i]);
  end

  i2c_avalon_bridge_mc #(.NUM_CH(NCH), .CLK_DIV(CDIV), .GPIO_W(GW), .LED_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write), .writedata(writedata),
    .read(read), .readdata(readdata), .scl(scl), .sda(sda), .gpio(gpio), .led(led)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ev_count = 0;
  int bus0_act = 0;
  int exp_q[$];
  logic [7:0] rd_bytes [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic got_event(input int ev);
    ev_count++;
    if (exp_q.size() == 0) check("unexpected_bus_event", ev, 32'hFFFF);
    else check("bus_event", ev, exp_q.pop_front());
  endtask

  // Slave model + monitor for bus 1, sampled on the falling clk edge away from DUT updates.
  initial begin
    logic pc, pd, c, d, in_txn, matched, reading, last_ack, rd_phase;
    logic [7:0] shreg;
    int bitpos, byte_no;
    pc = 1'b1; pd = 1'b1; in_txn = 1'b0; matched = 1'b0; reading = 1'b0; last_ack = 1'b1;
    shreg = '0; bitpos = 0; byte_no = 0;
    forever begin
      @(negedge clk);
      c = scl[1];
      d = sda[1];
      if (scl[0] !== 1'b1 || sda[0] !== 1'b1) bus0_act++;
      if (pc && c && pd && !d) begin
        got_event(in_txn ? EV_SR : EV_S);
        in_txn = 1'b1; bitpos = 0; byte_no = 0; matched = 1'b0; reading = 1'b0; slv_drv = 1'b0;
      end else if (pc && c && !pd && d) begin
        got_event(EV_P);
        in_txn = 1'b0; slv_drv = 1'b0;
      end else if (!pc && c) begin
        if (bitpos < 8) begin
          shreg = {shreg[6:0], d};
          bitpos++;
        end else begin
          got_event({23'd0, d, shreg});
          if (byte_no == 0) begin
            matched = (shreg[7:1] == SLV);
            reading = shreg[0];
          end
          last_ack = d;
          byte_no++;
          bitpos = 0;
        end
      end else if (pc && !c) begin
        rd_phase = matched && reading && (byte_no > 0);
        if (bitpos == 8)
          slv_drv = rd_phase ? 1'b0 : ((byte_no == 0) ? (shreg[7:1] == SLV) : matched);
        else if (bitpos == 0)
          slv_drv = (rd_phase && !last_ack) ? !rd_bytes[(byte_no - 1) % 4][7] : 1'b0;
        else
          slv_drv = rd_phase ? !rd_bytes[(byte_no - 1) % 4][7 - bitpos] : 1'b0;
      end
      pc = c;
      pd = d;
    end
  end

  // NOTE: bench inputs are driven with blocking assignments at negedge so the DUT samples settled values.
  task automatic wr(input logic [3:0] a, input logic [31:0] dat);
    address = a; writedata = dat; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] dat);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    dat = readdata;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      rd(4'd6, s);
      n++;
    end while (s[0] && n < 20000);
    check({tag, "_idle_in_time"}, {31'd0, s[0]}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int ev0;

    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 32'd0);
    check("rst_gpio", 32'(gpio), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_lines", {28'd0, scl, sda}, 32'hF);
    reset_n = 1'b1;
    @(negedge clk);
    rd(4'd6, d); check("rst_status", d, 32'd0);

    wr(4'd8, 32'h5);
    check("gpio_out", 32'(gpio), 32'h5);
    rd(4'd8, d); check("gpio_readback", d, 32'h5);
    rd(4'd9, d); check("unmapped_read", d, 32'd0);

    // Write of two bytes on bus 1; a mid-transfer GO and TX_DATA write must not disturb it.
    wr(4'd5, 32'd1); wr(4'd1, 32'h68); wr(4'd2, 32'h3B); wr(4'd3, 32'h0000BEEF); wr(4'd4, 32'd1);
    exp_q.push_back(EV_S);  exp_q.push_back(32'h0D0); exp_q.push_back(32'h03B);
    exp_q.push_back(32'h0EF); exp_q.push_back(32'h0BE); exp_q.push_back(EV_P);
    wr(4'd0, 32'h1);
    rd(4'd6, d); check("wr_busy", d, 32'h1);
    repeat (40) @(negedge clk);
    wr(4'd0, 32'h1);
    wr(4'd3, 32'h11112222);
    wait_idle("wr");
    rd(4'd6, d); check("wr_status", d, 32'h4);
    check("wr_queue_drained", exp_q.size(), 32'd0);
    check("wr_led", 32'(led), 32'h0C);

    // Read of two bytes with repeated START; master ACKs the first byte and NACKs the last.
    exp_q.push_back(EV_S);  exp_q.push_back(32'h0D0); exp_q.push_back(32'h03B);
    exp_q.push_back(EV_SR); exp_q.push_back(32'h0D1); exp_q.push_back(32'h012);
    exp_q.push_back(32'h134); exp_q.push_back(EV_P);
    wr(4'd0, 32'h3);
    rd(4'd0, d); check("ctrl_readback", d, 32'h2);
    wait_idle("rd");
    rd(4'd6, d); check("rd_status", d, 32'h4);
    rd(4'd7, d); check("rd_rx_data", d, 32'h00003412);
    check("rd_queue_drained", exp_q.size(), 32'd0);

    // Absent device: NACK on the address byte goes straight to STOP.
    wr(4'd1, 32'h50);
    exp_q.push_back(EV_S); exp_q.push_back(32'h1A0); exp_q.push_back(EV_P);
    wr(4'd0, 32'h1);
    wait_idle("nack");
    rd(4'd6, d); check("nack_status", d, 32'h6);
    rd(4'd7, d); check("nack_rx_cleared", d, 32'd0);
    check("nack_queue_drained", exp_q.size(), 32'd0);

    // Out-of-range channel: error flag only, no bus activity.
    wr(4'd5, 32'd5);
    ev0 = ev_count;
    wr(4'd0, 32'h1);
    rd(4'd6, d); check("cherr_status", d, 32'h8);
    repeat (100) @(negedge clk);
    check("cherr_no_bus_events", ev_count, ev0);
    rd(4'd6, d); check("cherr_still_idle", d, 32'h8);

    // Valid GO clears CH_ERR; TX_DATA written during the first transfer is now in effect.
    wr(4'd5, 32'd1); wr(4'd1, 32'h68); wr(4'd4, 32'd0);
    exp_q.push_back(EV_S); exp_q.push_back(32'h0D0); exp_q.push_back(32'h03B);
    exp_q.push_back(32'h022); exp_q.push_back(EV_P);
    wr(4'd0, 32'h1);
    rd(4'd6, d); check("recover_busy", d, 32'h1);
    wait_idle("recover");
    rd(4'd6, d); check("recover_status", d, 32'h4);
    check("recover_queue_drained", exp_q.size(), 32'd0);
    check("txn_counter_led", 32'(led), 32'h24);

    // Reset while the master is holding both lines low in the address byte.
    exp_q.push_back(EV_S);
    wr(4'd0, 32'h1);
    repeat (53) @(negedge clk);
    check("pre_reset_lines_low", {30'd0, scl[1], sda[1]}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("reset_lines_released", {28'd0, scl, sda}, 32'hF);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(4'd6, d); check("post_reset_status", d, 32'd0);
    check("post_reset_led", 32'(led), 32'd0);
    check("bus0_never_driven", bus0_act, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
